// File: rtl/dm_arbiter_if.sv
// Bus bundle between the N_CORES requesting cores, the dm_arbiter and the shared
// single-port data memory.
//
// Core side : req, wr, addr, wdata (cores -> arbiter); gnt, rvalid, rdata, busy
//             (arbiter -> cores). Per-core fields are packed, core i at
//             [i*W +: W].
// Memory side: mem_addr, mem_wr, mem_wdata (arbiter -> memory); mem_rdata
//             (memory -> arbiter, valid one cycle after the address).
//
// Modports:
//   slave  - the arbiter's view.
//   master - the view of whatever drives the cores and models the memory.
interface dm_arbiter_if #(
  parameter int unsigned N_CORES = 4,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 8
) ();

  logic [N_CORES-1:0]        req;
  logic [N_CORES-1:0]        wr;
  logic [N_CORES*ADDR_W-1:0] addr;
  logic [N_CORES*DATA_W-1:0] wdata;
  logic [N_CORES-1:0]        gnt;
  logic [N_CORES-1:0]        rvalid;
  logic [DATA_W-1:0]         rdata;
  logic                      busy;
  logic [ADDR_W-1:0]         mem_addr;
  logic                      mem_wr;
  logic [DATA_W-1:0]         mem_wdata;
  logic [DATA_W-1:0]         mem_rdata;

  modport slave (
    input  req, wr, addr, wdata, mem_rdata,
    output gnt, rvalid, rdata, busy, mem_addr, mem_wr, mem_wdata
  );

  modport master (
    output req, wr, addr, wdata, mem_rdata,
    input  gnt, rvalid, rdata, busy, mem_addr, mem_wr, mem_wdata
  );

endinterface

// File: rtl/dm_arbiter.sv
// Shared data-memory arbiter for the multi-core matrix multiplier.
//
// One single-port synchronous memory is shared by N_CORES cores. Each request is
// one read or one write. A winner is chosen in IDLE, granted for exactly one
// cycle (GRANT, memory access issued), and reads spend one more cycle in WAIT_RD
// while the memory returns data; rdata/rvalid appear the cycle after that.
//
// Ports:
//   clk   - system clock, rising edge.
//   rst_n - asynchronous active-low reset; abandons any transaction in flight.
//   bus   - dm_arbiter_if.slave: core req/wr/addr/wdata in, gnt/rvalid/rdata/busy
//           out, memory mem_addr/mem_wr/mem_wdata out, mem_rdata in.
//
// Build option:
//   DM_ARB_FIXED_PRIO_EN - when defined, fixed priority (lowest index wins) and no
//   round-robin pointer exists. Undefined (default): round-robin starting after
//   the last granted core, core 0 first out of reset.
module dm_arbiter #(
  parameter int unsigned N_CORES = 4,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  dm_arbiter_if.slave  bus
);

  localparam int unsigned IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  typedef enum logic [1:0] {StIdle, StGrant, StWaitRd} state_e;

  state_e           state_q;
  logic [IDX_W-1:0] sel_q;    // core owning the current transaction
  logic [IDX_W-1:0] win;      // combinational winner of the IDLE arbitration
  logic [IDX_W-1:0] win_lo;   // lowest requester (wrap-around / fixed priority)

`ifdef DM_ARB_FIXED_PRIO_EN

  always_comb begin
    win_lo = '0;
    // Descending scan: the last hit is the lowest requesting index.
    for (int i = N_CORES - 1; i >= 0; i--) begin
      if (bus.req[i]) win_lo = IDX_W'(i);
    end
    win = win_lo;
  end

`else

  logic [IDX_W-1:0] last_q;   // most recently granted core
  logic [IDX_W-1:0] win_hi;   // lowest requester strictly above last_q
  logic             hi_found;

  // Nearest requester after last_q, modulo N_CORES: prefer the lowest index above
  // last_q, otherwise wrap to the lowest index at or below it.
  always_comb begin
    win_lo   = '0;
    win_hi   = '0;
    hi_found = 1'b0;
    for (int i = N_CORES - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        if (IDX_W'(i) > last_q) begin
          win_hi   = IDX_W'(i);
          hi_found = 1'b1;
        end else begin
          win_lo = IDX_W'(i);
        end
      end
    end
    win = hi_found ? win_hi : win_lo;
  end

`endif

  assign bus.busy = (state_q != StIdle);

  // Single FSM; every core/memory output is a register. mem_addr, mem_wdata and
  // mem_wr double as the captured request, so they hold in IDLE and WAIT_RD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      sel_q         <= '0;
      bus.gnt       <= '0;
      bus.rvalid    <= '0;
      bus.rdata     <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_wr    <= 1'b0;
`ifndef DM_ARB_FIXED_PRIO_EN
      last_q        <= IDX_W'(N_CORES - 1);
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          bus.rvalid <= '0;
          if (|bus.req) begin
            sel_q         <= win;
            bus.gnt       <= N_CORES'(1) << win;
            bus.mem_addr  <= bus.addr[win * ADDR_W +: ADDR_W];
            bus.mem_wdata <= bus.wdata[win * DATA_W +: DATA_W];
            bus.mem_wr    <= bus.wr[win];
            state_q       <= StGrant;
          end
        end

        StGrant: begin
          bus.gnt    <= '0;
          bus.mem_wr <= 1'b0;
`ifndef DM_ARB_FIXED_PRIO_EN
          last_q     <= sel_q;
`endif
          // mem_wr still holds the captured direction during GRANT.
          state_q    <= bus.mem_wr ? StIdle : StWaitRd;
        end

        StWaitRd: begin
          bus.rdata  <= bus.mem_rdata;
          bus.rvalid <= N_CORES'(1) << sel_q;
          state_q    <= StIdle;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed scenarios plus randomized batches.
// A transaction-level model predicts grant order, cycle of every gnt/rvalid and
// read data; a monitor compares the DUT against the queued predictions.
module tb_dm_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
  localparam int unsigned MAXTX = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic mem_clr;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dm_arbiter_if #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  dm_arbiter #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Memory model: synchronous read, decodes the low address byte.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (bus.mem_wr) begin
      mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end
    bus.mem_rdata <= mem[bus.mem_addr[7:0]];
  end

  typedef struct {
    int          core;
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  data;
    int          cyc;
  } exp_t;

  exp_t gq[$];
  exp_t rq[$];

  // Per-core transaction lists for one batch.
  logic        t_wr   [N][MAXTX];
  logic [15:0] t_addr [N][MAXTX];
  logic [7:0]  t_data [N][MAXTX];
  int          t_cnt  [N];

  logic [7:0] shadow [256];
  int         m_last;
  int         n_chk;
  int         n_pass;
  int         wr_viol;
  logic [7:0] exp_rd;
  logic       busy_chk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic clr_batch();
    for (int i = 0; i < N; i++) t_cnt[i] = 0;
  endtask

  task automatic add_tx(input int c, input logic w, input logic [15:0] a, input logic [7:0] d);
    t_wr[c][t_cnt[c]]   = w;
    t_addr[c][t_cnt[c]] = a;
    t_data[c][t_cnt[c]] = d;
    t_cnt[c]++;
  endtask

  task automatic drive_core(input int c, input int p);
    if (p < t_cnt[c]) begin
      bus.req[c]              = 1'b1;
      bus.wr[c]               = t_wr[c][p];
      bus.addr[c*AW +: AW]    = t_addr[c][p];
      bus.wdata[c*DW +: DW]   = t_data[c][p];
    end else begin
      bus.req[c] = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    m_last = N - 1;
    @(posedge clk);
    #1;
  endtask

  // Predict the whole batch, then drive it. Every core with work left keeps
  // requesting, so each arbitration sees all of them.
  task automatic run_batch();
    int   mpos [N];
    int   pos  [N];
    int   left;
    int   total;
    int   t;
    int   w;
    int   budget;
    exp_t e;
    exp_t r;
    left = 0;
    for (int i = 0; i < N; i++) begin
      mpos[i] = 0;
      pos[i]  = 0;
      left   += t_cnt[i];
    end
    total = left;
    t = cyc + 1;
    while (left > 0) begin
      w = -1;
`ifdef DM_ARB_FIXED_PRIO_EN
      for (int i = N - 1; i >= 0; i--) if (mpos[i] < t_cnt[i]) w = i;
`else
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (w < 0 && mpos[c] < t_cnt[c]) w = c;
      end
      m_last = w;
`endif
      e.core = w;
      e.wr   = t_wr[w][mpos[w]];
      e.addr = t_addr[w][mpos[w]];
      e.data = t_data[w][mpos[w]];
      e.cyc  = t;
      gq.push_back(e);
      if (e.wr) begin
        shadow[e.addr[7:0]] = e.data;
        t += 2;
      end else begin
        r.core = w;
        r.wr   = 1'b0;
        r.addr = e.addr;
        r.data = shadow[e.addr[7:0]];
        r.cyc  = t + 2;
        rq.push_back(r);
        t += 3;
      end
      mpos[w]++;
      left--;
    end

    for (int i = 0; i < N; i++) drive_core(i, 0);
    left   = total;
    budget = 0;
    while (left > 0 && budget < 200) begin
      @(posedge clk);
      #1;
      budget++;
      for (int i = 0; i < N; i++) begin
        if (bus.req[i] && bus.gnt[i]) begin
          pos[i]++;
          left--;
          drive_core(i, pos[i]);
        end
      end
    end
    if (left != 0) begin
      check("grant_timeout", left, 0);
      bus.req = '0;
    end
    budget = 0;
    while ((gq.size() != 0 || rq.size() != 0 || bus.busy) && budget < 20) begin
      @(posedge clk);
      #2;
      budget++;
    end
    if (gq.size() != 0 || rq.size() != 0) begin
      check("drain_timeout", gq.size() + rq.size(), 0);
      gq.delete();
      rq.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk    = 0;
    n_pass   = 0;
    wr_viol  = 0;
    exp_rd   = '0;
    busy_chk = 1'b0;
    m_last   = N - 1;
    bus.req   = '0;
    bus.wr    = '0;
    bus.addr  = '0;
    bus.wdata = '0;
    for (int i = 0; i < 256; i++) shadow[i] = '0;
    mem_clr = 1'b1;
    rst_n   = 1'b0;

    fork
      begin : monitor
        exp_t me;
        forever begin
          @(posedge clk);
          #1;
          if (!rst_n) begin
            exp_rd   = '0;
            busy_chk = 1'b0;
          end else begin
            if (busy_chk) begin
              check("busy_after_write", bus.busy, 0);
              busy_chk = 1'b0;
            end
            if (bus.mem_wr && !(|bus.gnt)) wr_viol++;
            if (|bus.rvalid) begin
              if (rq.size() == 0) begin
                check("unexpected_rvalid", bus.rvalid, 0);
              end else begin
                me = rq.pop_front();
                check("rvalid_vec", bus.rvalid, 1 << me.core);
                check("rvalid_cycle", cyc, me.cyc);
                check("rdata", bus.rdata, me.data);
                check("busy_at_rvalid", bus.busy, 0);
                exp_rd = me.data;
              end
            end
            if (|bus.gnt) begin
              if (gq.size() == 0) begin
                check("unexpected_gnt", bus.gnt, 0);
              end else begin
                me = gq.pop_front();
                check("gnt_vec", bus.gnt, 1 << me.core);
                check("gnt_cycle", cyc, me.cyc);
                check("mem_wr", bus.mem_wr, me.wr);
                check("mem_addr", bus.mem_addr, me.addr);
                check("mem_wdata", bus.mem_wdata, me.data);
                check("rdata_hold", bus.rdata, exp_rd);
                check("busy_at_gnt", bus.busy, 1);
                busy_chk = me.wr;
              end
            end
          end
        end
      end
    join_none

    // Reset values.
    @(posedge clk);
    #1;
    mem_clr = 1'b0;
    check("rst_gnt", bus.gnt, 0);
    check("rst_rvalid", bus.rvalid, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_mem_wr", bus.mem_wr, 0);
    check("rst_busy", bus.busy, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    m_last = N - 1;
    @(posedge clk);
    #1;

    // Core 1 write, then core 2 reads it back.
    clr_batch();
    add_tx(1, 1'b1, 16'h0040, 8'hA5);
    run_batch();
    clr_batch();
    add_tx(2, 1'b0, 16'h0040, 8'h00);
    run_batch();

    // All four cores requesting continuously from reset.
    do_reset();
    clr_batch();
    for (int c = 0; c < N; c++) begin
      add_tx(c, 1'($urandom_range(0, 1)), {8'h10, 8'(c)}, 8'($urandom_range(0, 255)));
      add_tx(c, 1'($urandom_range(0, 1)), {8'h20, 8'(c + 4)}, 8'($urandom_range(0, 255)));
    end
    run_batch();

    // Cores 0 and 3 after reset (last = 3).
    do_reset();
    clr_batch();
    add_tx(0, 1'b1, 16'h0050, 8'h11);
    add_tx(3, 1'b0, 16'h0050, 8'h00);
    run_batch();

    // Reset during the GRANT cycle of a write: the write must not land.
    do_reset();
    begin
      exp_t ab;
      logic [7:0] dat;
      dat = ~shadow[8'h77];
      bus.req[2]            = 1'b1;
      bus.wr[2]             = 1'b1;
      bus.addr[2*AW +: AW]  = 16'h0077;
      bus.wdata[2*DW +: DW] = dat;
      ab.core = 2;
      ab.wr   = 1'b1;
      ab.addr = 16'h0077;
      ab.data = dat;
      ab.cyc  = cyc + 1;
      gq.push_back(ab);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      bus.req[2] = 1'b0;
      #1;
      check("abort_mem_wr", bus.mem_wr, 0);
      check("abort_gnt", bus.gnt, 0);
      check("abort_busy", bus.busy, 0);
      @(posedge clk);
      @(negedge clk);
      rst_n  = 1'b1;
      m_last = N - 1;
      check("abort_mem_unwritten", mem[8'h77], shadow[8'h77]);
      check("abort_rvalid", bus.rvalid, 0);
      check("abort_rdata", bus.rdata, 0);
      repeat (4) @(posedge clk);
      #1;
      check("abort_gq_consumed", gq.size(), 0);
    end
    clr_batch();
    add_tx(2, 1'b1, 16'h0078, 8'h5A);
    add_tx(0, 1'b1, 16'h0079, 8'hC3);
    run_batch();

    // Core 1 keeps req high across two reads.
    clr_batch();
    add_tx(1, 1'b0, 16'h0078, 8'h00);
    add_tx(1, 1'b0, 16'h0079, 8'h00);
    run_batch();

    // Randomized batches.
    for (int b = 0; b < 25; b++) begin
      clr_batch();
      for (int c = 0; c < N; c++) begin
        int n;
        n = $urandom_range(0, 3);
        for (int k = 0; k < n; k++) begin
          add_tx(c, 1'($urandom_range(0, 1)),
                 {8'($urandom_range(0, 255)), 8'($urandom_range(0, 15))},
                 8'($urandom_range(0, 255)));
        end
      end
      run_batch();
    end

    check("mem_wr_outside_grant", wr_viol, 0);
    check("gq_empty", gq.size(), 0);
    check("rq_empty", rq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
